deterministic_updater_gen: RTL and testbench

DETERMINISTIC_UPDATER_GEN -- requirements
Module: deterministic_updater_gen

---
 rtl/deterministic_updater_pkg.sv | 16 +
 rtl/du_residual_lane.sv | 38 +++
 rtl/deterministic_updater_gen.sv | 122 ++++++++++++
 tb/tb_deterministic_updater_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/deterministic_updater_pkg.sv
// Shared state encoding and residual-step arithmetic for the deterministic updater.
package deterministic_updater_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEncode,
    StStream,
    StDone
  } state_e;

  // Saturating subtract of one conductance step; never wraps below zero.
  function automatic logic [31:0] residual_step(input logic [31:0] res, input logic [31:0] dg);
    return (res > dg) ? res - dg : 32'd0;
  endfunction

endpackage

// File: rtl/du_residual_lane.sv
// One channel's captured value and residual, stepped by DG per encode row.
module du_residual_lane
  import deterministic_updater_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned DG = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         reload,
  output logic         nonzero,
  output logic         next_zero
);

  logic [W-1:0] cap_q;
  logic [W-1:0] res_q;
  logic [31:0]  step_wide;

  assign step_wide = residual_step(32'(res_q), 32'(DG));
  assign next_zero = (step_wide == 32'd0);
  assign nonzero   = (res_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
      res_q <= '0;
    end else if (load) begin
      cap_q <= load_val;
      res_q <= load_val;
    end else if (step) begin
      res_q <= reload ? cap_q : step_wide[W-1:0];
    end
  end

endmodule

// File: rtl/deterministic_updater_gen.sv
// Encodes x/delta magnitudes into rows of pulse bits, then streams the rows out.
module deterministic_updater_gen
  import deterministic_updater_pkg::*;
#(
  parameter int unsigned M        = 2,
  parameter int unsigned N        = 2,
  parameter int unsigned W        = 8,
  parameter int unsigned BL       = 10,
  parameter int unsigned DG       = 25,
  parameter int unsigned REPEAT_X = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [M*W-1:0]            x_in,
  input  logic [N*W-1:0]            delta_in,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(BL+1)-1:0]   n_rows,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      rd_last,
  output logic [$clog2(BL)-1:0]     rd_idx,
  output logic [M-1:0]              rd_x,
  output logic [N-1:0]              rd_delta
);

  localparam int unsigned CW = $clog2(BL + 1);
  localparam int unsigned IW = $clog2(BL);

  state_e        state_q, state_d;
  logic [IW-1:0] row_cnt_q;
  logic [IW-1:0] rd_ptr_q;
  logic [CW-1:0] n_rows_q;
  logic [M-1:0]  mem_x_q [BL];
  logic [N-1:0]  mem_d_q [BL];

  logic [M-1:0] x_nonzero, x_next_zero;
  logic [N-1:0] d_nonzero, d_next_zero;
  logic accept, step, x_reload, enc_last, hs;

  assign accept   = (state_q == StIdle) && start;
  assign step     = (state_q == StEncode);
  assign x_reload = (REPEAT_X != 0) && (&x_next_zero);
  assign enc_last = (&d_next_zero) || (row_cnt_q == IW'(BL - 1));
  assign hs       = rd_valid && rd_ready;

  for (genvar i = 0; i < M; i++) begin : g_x_lane
    du_residual_lane #(.W(W), .DG(DG)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (x_in[i*W +: W]),
      .step     (step),
      .reload   (x_reload),
      .nonzero  (x_nonzero[i]),
      .next_zero(x_next_zero[i])
    );
  end

  for (genvar j = 0; j < N; j++) begin : g_d_lane
    du_residual_lane #(.W(W), .DG(DG)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (delta_in[j*W +: W]),
      .step     (step),
      .reload   (1'b0),
      .nonzero  (d_nonzero[j]),
      .next_zero(d_next_zero[j])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = (delta_in == '0) ? StDone : StEncode;
      StEncode: if (enc_last) state_d = StStream;
      StStream: if (hs && rd_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      rd_ptr_q  <= '0;
      n_rows_q  <= '0;
      for (int k = 0; k < int'(BL); k++) begin
        mem_x_q[k] <= '0;
        mem_d_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        row_cnt_q <= '0;
        rd_ptr_q  <= '0;
        n_rows_q  <= '0;
      end
      if (step) begin
        mem_x_q[row_cnt_q] <= x_nonzero;
        mem_d_q[row_cnt_q] <= d_nonzero;
        if (enc_last) n_rows_q <= CW'(row_cnt_q) + CW'(1);
        else          row_cnt_q <= row_cnt_q + IW'(1);
      end
      if ((state_q == StStream) && hs && !rd_last) rd_ptr_q <= rd_ptr_q + IW'(1);
    end
  end

  // Outside STREAM the read port is forced quiet so stale rows never leak out.
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign n_rows   = n_rows_q;
  assign rd_valid = (state_q == StStream);
  assign rd_idx   = rd_valid ? rd_ptr_q : '0;
  assign rd_x     = rd_valid ? mem_x_q[rd_ptr_q] : '0;
  assign rd_delta = rd_valid ? mem_d_q[rd_ptr_q] : '0;
  assign rd_last  = rd_valid && (CW'(rd_ptr_q) == n_rows_q - CW'(1));

endmodule

// File: tb/tb_deterministic_updater_gen.sv
// Random and directed bench; two instances (REPEAT_X=1 and 0) share all stimulus.
module tb_deterministic_updater_gen;

  localparam int DG = 25;
  localparam int BL = 10;

  logic        clk = 1'b0;
  logic        rst, start, rd_ready;
  logic [15:0] x_in, delta_in;

  logic       busy1, done1, rd_valid1, rd_last1, busy0, done0, rd_valid0, rd_last0;
  logic [3:0] n_rows1, rd_idx1, n_rows0, rd_idx0;
  logic [1:0] rd_x1, rd_delta1, rd_x0, rd_delta0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  deterministic_updater_gen #(.REPEAT_X(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .delta_in(delta_in),
    .busy(busy1), .done(done1), .n_rows(n_rows1), .rd_valid(rd_valid1),
    .rd_ready(rd_ready), .rd_last(rd_last1), .rd_idx(rd_idx1), .rd_x(rd_x1),
    .rd_delta(rd_delta1)
  );

  deterministic_updater_gen #(.REPEAT_X(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .delta_in(delta_in),
    .busy(busy0), .done(done0), .n_rows(n_rows0), .rd_valid(rd_valid0),
    .rd_ready(rd_ready), .rd_last(rd_last0), .rd_idx(rd_idx0), .rd_x(rd_x0),
    .rd_delta(rd_delta0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference: a value v is "on" in row r while more than r steps of DG remain.
  function automatic int steps(input int v);
    return (v + DG - 1) / DG;
  endfunction

  function automatic int model_rows(input int d0, input int d1);
    int n = (steps(d0) > steps(d1)) ? steps(d0) : steps(d1);
    return (n > BL) ? BL : n;
  endfunction

  function automatic logic [1:0] model_d(input int d0, input int d1, input int r);
    return {logic'(d1 > r * DG), logic'(d0 > r * DG)};
  endfunction

  // With repeat, the x pattern is periodic with the longest x channel's step count.
  function automatic logic [1:0] model_x(input int x0, input int x1, input int r, input bit rep);
    int p, rr;
    p  = (steps(x0) > steps(x1)) ? steps(x0) : steps(x1);
    rr = r;
    if (rep) rr = (p == 0) ? 0 : r % p;
    return {logic'(x1 > rr * DG), logic'(x0 > rr * DG)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input int x0, input int x1, input int d0, input int d1,
                          input int stall_row, input int stall_len, input bit rnd_ready,
                          input bit glitch);
    int exp_n, ptr, stall_left, guard;
    bit rdy;
    exp_n = model_rows(d0, d1);
    x_in     = {8'(x1), 8'(x0)};
    delta_in = {8'(d1), 8'(d0)};
    start    = 1'b1;
    rd_ready = 1'b0;
    tick();
    start = 1'b0;
    if (exp_n == 0) begin
      check("zero_done", {done1, done0}, 2'b11);
      check("zero_nrows", n_rows1, 0);
      check("zero_valid", {rd_valid1, rd_valid0}, 2'b00);
      tick();
      check("zero_done_end", {done1, done0, busy1}, 3'b000);
      return;
    end
    for (int c = 0; c < exp_n; c++) begin
      check("enc_busy", {busy1, busy0}, 2'b11);
      check("enc_valid", {rd_valid1, rd_valid0}, 2'b00);
      if (glitch && c == 0) begin
        start    = 1'b1;
        x_in     = 16'($urandom);
        delta_in = 16'($urandom);
      end
      tick();
      start = 1'b0;
    end
    check("nrows1", n_rows1, exp_n);
    check("nrows0", n_rows0, exp_n);
    ptr        = 0;
    stall_left = stall_len;
    guard      = 0;
    while (ptr < exp_n && guard < 400) begin
      guard++;
      rdy = 1'b1;
      if (ptr == stall_row && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if (rnd_ready && $urandom_range(3) == 0) begin
        rdy = 1'b0;
      end
      rd_ready = rdy;
      check("rd_valid", {rd_valid1, rd_valid0}, 2'b11);
      check("rd_idx", {rd_idx1, rd_idx0}, {4'(ptr), 4'(ptr)});
      check("rd_x1", rd_x1, model_x(x0, x1, ptr, 1'b1));
      check("rd_x0", rd_x0, model_x(x0, x1, ptr, 1'b0));
      check("rd_delta", {rd_delta1, rd_delta0},
            {model_d(d0, d1, ptr), model_d(d0, d1, ptr)});
      check("rd_last", {rd_last1, rd_last0}, {2{ptr == exp_n - 1}});
      check("no_done_stream", {done1, done0}, 2'b00);
      tick();
      if (rdy) ptr++;
    end
    if (guard >= 400) check("stream_timeout", 0, 1);
    rd_ready = 1'b0;
    check("done_pulse", {done1, done0, rd_valid1, rd_valid0}, 4'b1100);
    tick();
    check("done_end", {done1, done0, busy1, busy0}, 4'b0000);
    check("nrows_hold", n_rows1, exp_n);
  endtask

  task automatic reset_mid_encode();
    x_in     = {8'd10, 8'd200};
    delta_in = {8'd0, 8'd255};
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_busy", {busy1, busy0}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", {busy1, busy0}, 2'b00);
    check("rst_valid", {rd_valid1, rd_valid0}, 2'b00);
    check("rst_nrows", n_rows1, 0);
    for (int c = 0; c < 12; c++) begin
      check("rst_no_done", {done1, done0, rd_valid1}, 3'b000);
      tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rd_ready = 1'b0;
    x_in     = '0;
    delta_in = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_outs", {busy1, done1, rd_valid1, busy0, done0, rd_valid0}, 6'b0);
    check("reset_nrows", n_rows1, 0);

    run_case(60, 30, 50, 10, -1, 0, 1'b0, 1'b0);
    run_case(20, 0, 100, 0, -1, 0, 1'b0, 1'b0);
    run_case(20, 0, 255, 0, -1, 0, 1'b0, 1'b0);
    run_case(5, 7, 0, 0, -1, 0, 1'b0, 1'b0);
    run_case(20, 0, 100, 0, 1, 3, 1'b0, 1'b0);
    run_case(90, 40, 100, 0, -1, 0, 1'b0, 1'b1);
    reset_mid_encode();
    run_case(60, 30, 50, 10, -1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      int d0, d1;
      d0 = $urandom_range(255, 0);
      d1 = ($urandom_range(3) == 0) ? 0 : $urandom_range(255, 0);
      if (k % 8 == 7) begin
        d0 = 0;
        d1 = 0;
      end
      run_case($urandom_range(255, 0), $urandom_range(255, 0), d0, d1,
               $urandom_range(4, 0), $urandom_range(3, 0), 1'b1, k[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
